// File: rtl/xbus_uart_pkg.sv
// Shared xbus constants for the UART slot: slave indices, register offsets,
// STATUS bit positions and the TX/RX state encodings.
package xbus_uart_pkg;

  localparam int NSLAVES  = 2;
  localparam int SLV_RAM  = 0;
  localparam int SLV_UART = 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RXDATA = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_RX_VALID = 3;
  localparam int ST_OVERFLOW = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/xbus_uart_if.sv
// xbus responder-side signal bundle; the core drives it through the master modport.
interface xbus_uart_if;
  logic        cs;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output cs, we, be, addr, wdata, input rdata);
  modport slave  (input cs, we, be, addr, wdata, output rdata);
endinterface

// File: rtl/xbus_uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is still
// accepted when a pop happens on the same clock.
module xbus_uart_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/xbus_uart.sv
// Memory-mapped 8N1 UART on xbus (slave 1): TX FIFO + serializer, STATUS polling.
// Optional receiver enabled by defining XBUS_UART_RX_EN.
module xbus_uart
  import xbus_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  xbus_uart_if.slave  xbus,
  output logic        uart_tx
`ifdef XBUS_UART_RX_EN
  ,
  input  logic        uart_rx
`endif
);
  localparam int              CNT_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);

  tx_state_t        tx_state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             overflow;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [7:0]       fifo_dout;
  logic [1:0]       reg_sel;
  logic             wr_tx, wr_stat_clr, tx_drop;
  logic             rx_valid, rx_ovf_set;
  logic [7:0]       rx_byte;
  logic             unused_bus;

  assign reg_sel     = xbus.addr[3:2];
  assign wr_tx       = xbus.cs && xbus.we && xbus.be[0] && (reg_sel == REG_TXDATA);
  assign wr_stat_clr = xbus.cs && xbus.we && xbus.be[0] && (reg_sel == REG_STATUS)
                       && xbus.wdata[ST_OVERFLOW];
  assign fifo_pop    = (tx_state == TX_IDLE) && !fifo_empty;
  assign tx_drop     = wr_tx && fifo_full && !fifo_pop;
  assign unused_bus  = ^{xbus.addr[31:4], xbus.addr[1:0], xbus.wdata[31:8], xbus.be[3:1]};

  xbus_uart_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .din   (xbus.wdata[7:0]),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // uart_tx is loaded with the level of the state being entered, so it is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (!fifo_empty) begin
            shift_q  <= fifo_dout;
            baud_cnt <= '0;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_tx  <= shift_q[0];
            tx_state <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              uart_tx <= shift_q[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx_state <= TX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Setting wins over a software clear landing on the same clock.
  always_ff @(posedge clk) begin
    if (rst)                         overflow <= 1'b0;
    else if (tx_drop || rx_ovf_set)  overflow <= 1'b1;
    else if (wr_stat_clr)            overflow <= 1'b0;
  end

`ifdef XBUS_UART_RX_EN
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(CLK_DIV / 2 - 1);

  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_s3;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rd_rx, rx_done;

  assign rd_rx      = xbus.cs && !xbus.we && (reg_sel == REG_RXDATA);
  assign rx_done    = (rx_state == RX_STOP) && (rx_cnt == BAUD_LAST) && rx_s2;
  assign rx_ovf_set = rx_done && rx_valid && !rd_rx;

  // rx_s3 is the previous synchronized level, used only for start-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (rx_done) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2 && rx_s3) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == BAUD_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
`else
  assign rx_valid   = 1'b0;
  assign rx_byte    = '0;
  assign rx_ovf_set = 1'b0;
`endif

  always_comb begin
    xbus.rdata = '0;
    if (xbus.cs) begin
      case (reg_sel)
        REG_STATUS: begin
          xbus.rdata[ST_TX_FULL]  = fifo_full;
          xbus.rdata[ST_TX_EMPTY] = fifo_empty;
          xbus.rdata[ST_TX_BUSY]  = (tx_state != TX_IDLE);
          xbus.rdata[ST_RX_VALID] = rx_valid;
          xbus.rdata[ST_OVERFLOW] = overflow;
        end
        REG_RXDATA: xbus.rdata[7:0] = rx_byte;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_uart.sv
// Directed self-checking bench for xbus_uart with CLK_DIV=4, FIFO_DEPTH=4.
module tb_xbus_uart;
  import xbus_uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic uart_tx;
`ifdef XBUS_UART_RX_EN
  logic uart_rx;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] s;

  xbus_uart_if bus();

  xbus_uart #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .xbus    (bus),
    .uart_tx (uart_tx)
`ifdef XBUS_UART_RX_EN
    ,
    .uart_rx (uart_rx)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write commits at the following posedge.
  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] be);
    bus.cs = 1'b1; bus.we = 1'b1; bus.be = be;
    bus.addr = {28'h0, r, 2'b00}; bus.wdata = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] d;
    bus.cs = 1'b1; bus.we = 1'b0; bus.be = 4'h0; bus.addr = {28'h0, r, 2'b00};
    #1 d = bus.rdata;
    chk(tag, d, exp);
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  // Combinational STATUS look that never spans a clock edge.
  task automatic peek(output logic [31:0] d);
    bus.cs = 1'b1; bus.we = 1'b0; bus.be = 4'h0; bus.addr = {28'h0, REG_STATUS, 2'b00};
    #1 d = bus.rdata;
    bus.cs = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] b);
    logic [31:0] st;
    logic        e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4)       e = 1'b0;
      else if (i < 36) e = b[(i - 4) / 4];
      else             e = 1'b1;
      chk($sformatf("%s tx[%0d]", tag, i), {31'h0, uart_tx}, {31'h0, e});
      peek(st);
      chk($sformatf("%s busy[%0d]", tag, i), {31'h0, st[2]}, 32'h1);
    end
  endtask

  task automatic idle_gap(input string tag);
    logic [31:0] st;
    @(negedge clk);
    peek(st);
    chk({tag, " gap tx"}, {31'h0, uart_tx}, 32'h1);
    chk({tag, " gap busy"}, {31'h0, st[2]}, 32'h0);
  endtask

  task automatic wait_idle(input string tag, input int max);
    logic [31:0] st;
    int n = 0;
    do begin
      @(negedge clk);
      peek(st);
      n++;
    end while (st[2] && n < max);
    chk({tag, " idle reached"}, {31'h0, st[2]}, 32'h0);
    chk({tag, " idle tx"}, {31'h0, uart_tx}, 32'h1);
  endtask

`ifdef XBUS_UART_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask
`endif

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.be = 4'h0; bus.addr = '0; bus.wdata = '0;
    rst = 1'b1;
`ifdef XBUS_UART_RX_EN
    uart_rx = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("reset tx", {31'h0, uart_tx}, 32'h1);
    rst = 1'b0;

    // Reset state and register map
    chk_rd("reset status", REG_STATUS, 32'h2);
    chk_rd("txdata reads 0", REG_TXDATA, 32'h0);
    chk_rd("reserved reads 0", REG_RSVD, 32'h0);
`ifndef XBUS_UART_RX_EN
    chk_rd("rxdata reads 0", REG_RXDATA, 32'h0);
`endif
    bus.addr = {28'h0, REG_STATUS, 2'b00};
    #1 chk("rdata with cs low", bus.rdata, 32'h0);
    @(negedge clk);
    wr(REG_RSVD, 32'hFFFF_FFFF, 4'hF);
    chk_rd("status after reserved write", REG_STATUS, 32'h2);

    // Single frame 0x55
    wr(REG_TXDATA, 32'h55, 4'h1);
    peek(s);
    chk("pre-pop tx", {31'h0, uart_tx}, 32'h1);
    chk("pre-pop status", s, 32'h0);
    expect_frame("f55", 8'h55);
    idle_gap("f55");
    peek(s);
    chk("after f55 status", s, 32'h2);

    // Overflow: six back-to-back pushes, five accepted
    wr(REG_TXDATA, 32'h11, 4'h1);
    wr(REG_TXDATA, 32'h22, 4'h1);
    wr(REG_TXDATA, 32'h33, 4'h1);
    wr(REG_TXDATA, 32'h44, 4'h1);
    wr(REG_TXDATA, 32'h66, 4'h1);
    wr(REG_TXDATA, 32'h77, 4'h1);
    chk_rd("ovf status", REG_STATUS, 32'h15);
    wr(REG_STATUS, 32'h10, 4'h0);
    chk_rd("ovf clear needs be0", REG_STATUS, 32'h15);
    wr(REG_STATUS, 32'h10, 4'h1);
    chk_rd("ovf cleared", REG_STATUS, 32'h05);
    wait_idle("ovf f11", 60);
    expect_frame("f22", 8'h22);
    idle_gap("f22");
    expect_frame("f33", 8'h33);
    idle_gap("f33");
    expect_frame("f44", 8'h44);
    idle_gap("f44");
    expect_frame("f66", 8'h66);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("no 6th frame tx[%0d]", i), {31'h0, uart_tx}, 32'h1);
    end
    peek(s);
    chk("dropped byte not queued", s, 32'h2);

    // Push into a full FIFO on the same clock as the FSM pop
    wr(REG_TXDATA, 32'h01, 4'h1);
    wr(REG_TXDATA, 32'h5A, 4'h1);
    wr(REG_TXDATA, 32'hC3, 4'h1);
    wr(REG_TXDATA, 32'h0F, 4'h1);
    wr(REG_TXDATA, 32'hF0, 4'h1);
    chk_rd("full status", REG_STATUS, 32'h05);
    wait_idle("fill f01", 60);
    wr(REG_TXDATA, 32'h99, 4'h1);
    chk_rd("push on pop status", REG_STATUS, 32'h05);
    wait_idle("fill f5A", 60);
    expect_frame("fC3", 8'hC3);
    idle_gap("fC3");
    expect_frame("f0F", 8'h0F);
    idle_gap("f0F");
    expect_frame("fF0", 8'hF0);
    idle_gap("fF0");
    expect_frame("f99", 8'h99);
    idle_gap("f99");
    peek(s);
    chk("after fill status", s, 32'h2);

    // Reset in the middle of the data bits of 0xA5
    wr(REG_TXDATA, 32'hA5, 4'h1);
    wr(REG_TXDATA, 32'h3C, 4'h1);
    repeat (8) @(negedge clk);
    chk("A5 bit1 before reset", {31'h0, uart_tx}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("tx after mid-frame reset", {31'h0, uart_tx}, 32'h1);
    rst = 1'b0;
    chk_rd("status after mid-frame reset", REG_STATUS, 32'h2);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk($sformatf("no frame after reset tx[%0d]", i), {31'h0, uart_tx}, 32'h1);
    end
    peek(s);
    chk("final status", s, 32'h2);

`ifdef XBUS_UART_RX_EN
    // Receiver: good frame, then a frame with a bad stop bit
    send_rx(8'h3C, 1'b1);
    peek(s);
    chk("rx_valid set", {31'h0, s[3]}, 32'h1);
    chk_rd("rxdata", REG_RXDATA, 32'h3C);
    peek(s);
    chk("rx_valid cleared", {31'h0, s[3]}, 32'h0);
    send_rx(8'h81, 1'b0);
    peek(s);
    chk("bad stop rx_valid", {31'h0, s[3]}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
